// File: rtl/cpu_pkg.sv
// Shared datapath definitions used by the divider and its step unit.
package cpu_pkg;

    localparam int DATA_WIDTH = 32;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Quotient reported when the divisor is zero.
    localparam logic [DATA_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes.
// The shifted remainder is held in WIDTH+1 bits, so the trial
// subtraction cannot overflow even for a 0x80000000 divisor.
module div_step
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] dvs_mag,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Shift in the next dividend bit, trial-subtract, and restore on borrow.
    always_comb begin
        shifted = {rem_in, dvd_bit};
        diff    = shifted - {1'b0, dvs_mag};
        if (!diff[WIDTH]) begin
            rem_out = diff[WIDTH-1:0];
            q_bit   = 1'b1;
        end else begin
            rem_out = shifted[WIDTH-1:0];
            q_bit   = 1'b0;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed divider feeding the ZHI/ZLO pair.
// result = {remainder, quotient}; quotient truncates toward zero and
// the remainder carries the sign of the dividend.
module seq_divider
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [2*WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    div_state_t state;
    div_state_t next_state;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs_mag;
    logic             sign_q;
    logic             sign_r;

    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic             divisor_zero;

    // Two's-complement magnitudes; the most negative value wraps onto itself,
    // which is exactly its unsigned magnitude.
    assign dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
    assign divisor_zero = (divisor == '0);

    // The quotient register doubles as the dividend shift register:
    // its MSB feeds the step while the new quotient bit enters at the LSB.
    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_in (rem),
        .dvd_bit(quo[WIDTH-1]),
        .dvs_mag(dvs_mag),
        .rem_out(step_rem),
        .q_bit  (step_q)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and status outputs; start is only honoured in IDLE.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = divisor_zero ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (count == '0) begin
                    next_state = FIX;
                end
            end
            FIX: begin
                busy       = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand capture, iteration, sign fix-up and result holding.
    always_ff @(posedge clock) begin
        if (reset) begin
            count       <= '0;
            rem         <= '0;
            quo         <= '0;
            dvs_mag     <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sign_r  <= dividend[WIDTH-1];
                        quo     <= dividend_mag;
                        dvs_mag <= divisor_mag;
                        rem     <= '0;
                        count   <= CW'(WIDTH - 1);
                        if (divisor_zero) begin
                            result      <= {dividend, WIDTH'(DIV_ZERO_QUOTIENT)};
                            div_by_zero <= 1'b1;
                        end else begin
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    rem   <= step_rem;
                    quo   <= {quo[WIDTH-2:0], step_q};
                    count <= count - 1'b1;
                end
                FIX: begin
                    result <= {(sign_r ? -rem : rem), (sign_q ? -quo : quo)};
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed table, randomized runs
// against an arithmetic reference model, and multi-cycle corner sequences.
module tb_seq_divider;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [63:0] result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic [31:0] exp_q;
        logic [31:0] exp_r;
        logic        exp_dbz;
    } vec_t;

    vec_t vecs[12];

    seq_divider dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .result     (result)
    );

    // Free-running clock, 10 time units per period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compare one value and log a failure line on mismatch.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: signed division done in 64-bit arithmetic, so the
    // most-negative / -1 case simply wraps when truncated to 32 bits.
    function automatic void refModel(input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] q, output logic [31:0] r,
                                     output logic z);
        longint sa;
        longint sb;
        sa = $signed(a);
        sb = $signed(b);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
            z = 1'b0;
        end
    endfunction

    // Issue one division and watch it to completion. lat counts rising
    // edges after the start edge until done is seen; operands are scrambled
    // after the start edge, and start is re-pulsed at edge disturb_at.
    task automatic applyStimulus(input logic [31:0] dvd, input logic [31:0] dvs,
                                 input int disturb_at,
                                 output logic [63:0] res, output logic dbz,
                                 output int lat, output int busy_cycles,
                                 output logic done_seen, output logic done_after);
        @(negedge clock);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        @(posedge clock);
        lat         = 0;
        busy_cycles = 0;
        done_seen   = 1'b0;
        done_after  = 1'b0;
        res         = '0;
        dbz         = 1'b0;
        for (int guard = 0; guard < 100; guard++) begin
            @(negedge clock);
            if (busy) busy_cycles++;
            if (done) begin
                done_seen = 1'b1;
                res       = result;
                dbz       = div_by_zero;
                break;
            end
            start    = (lat == disturb_at);
            dividend = $urandom;
            divisor  = $urandom;
            @(posedge clock);
            lat++;
        end
        start = 1'b0;
        if (done_seen) begin
            @(negedge clock);
            done_after = done;
        end
    endtask

    // Run one division and compare everything against the given expectation.
    task automatic runAndCheck(input string name, input logic [31:0] dvd, input logic [31:0] dvs,
                               input logic [31:0] exp_q, input logic [31:0] exp_r,
                               input logic exp_dbz, input int disturb_at);
        logic [63:0] res;
        logic        dbz;
        int          lat;
        int          bc;
        logic        seen;
        logic        after;
        applyStimulus(dvd, dvs, disturb_at, res, dbz, lat, bc, seen, after);
        checkOutput({name, " done_seen"}, 64'(seen), 64'd1);
        checkOutput({name, " quotient"}, 64'(res[31:0]), 64'(exp_q));
        checkOutput({name, " remainder"}, 64'(res[63:32]), 64'(exp_r));
        checkOutput({name, " div_by_zero"}, 64'(dbz), 64'(exp_dbz));
        checkOutput({name, " latency"}, 64'(lat), exp_dbz ? 64'd0 : 64'd33);
        checkOutput({name, " busy_cycles"}, 64'(bc), exp_dbz ? 64'd0 : 64'd33);
        checkOutput({name, " done_one_cycle"}, 64'(after), 64'd0);
    endtask

    initial begin
        logic [31:0] rq;
        logic [31:0] rr;
        logic        rz;
        logic [31:0] a;
        logic [31:0] b;
        int          waited;

        vecs[0]  = '{"100/7",        32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
        vecs[1]  = '{"-100/7",       -32'd100,      32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0};
        vecs[2]  = '{"100/-7",       32'd100,       -32'd7,        32'hFFFF_FFF2, 32'd2,         1'b0};
        vecs[3]  = '{"7/0",          32'd7,         32'd0,         32'hFFFF_FFFF, 32'd7,         1'b1};
        vecs[4]  = '{"9/3",          32'd9,         32'd3,         32'd3,         32'd0,         1'b0};
        vecs[5]  = '{"min/-1",       32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0};
        vecs[6]  = '{"0/5",          32'd0,         32'd5,         32'd0,         32'd0,         1'b0};
        vecs[7]  = '{"min/1",        32'h8000_0000, 32'd1,         32'h8000_0000, 32'd0,         1'b0};
        vecs[8]  = '{"min/min",      32'h8000_0000, 32'h8000_0000, 32'd1,         32'd0,         1'b0};
        vecs[9]  = '{"max/min",      32'h7FFF_FFFF, 32'h8000_0000, 32'd0,         32'h7FFF_FFFF, 1'b0};
        vecs[10] = '{"-1/min",       32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         32'hFFFF_FFFF, 1'b0};
        vecs[11] = '{"-min/0",       32'h8000_0000, 32'd0,         32'hFFFF_FFFF, 32'h8000_0000, 1'b1};

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clock);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset div_by_zero", 64'(div_by_zero), 64'd0);
        checkOutput("reset result", result, 64'd0);
        reset = 1'b0;

        $display("[TB] directed table");
        for (int i = 0; i < 12; i++) begin
            runAndCheck(vecs[i].name, vecs[i].dvd, vecs[i].dvs,
                        vecs[i].exp_q, vecs[i].exp_r, vecs[i].exp_dbz, -1);
        end

        $display("[TB] start and operand changes during CALC");
        runAndCheck("1000/7 disturbed", 32'd1000, 32'd7, 32'd142, 32'd6, 1'b0, 5);

        $display("[TB] start during DONE is ignored");
        @(negedge clock);
        dividend = 32'd20;
        divisor  = 32'd5;
        start    = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        waited = 0;
        while (!done && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        checkOutput("done_ignore reached", 64'(done), 64'd1);
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd3;
        @(negedge clock);
        start = 1'b0;
        checkOutput("done_ignore busy", 64'(busy), 64'd0);
        checkOutput("done_ignore done", 64'(done), 64'd0);
        @(negedge clock);
        checkOutput("done_ignore busy2", 64'(busy), 64'd0);
        checkOutput("done_ignore result", result, {32'd0, 32'd4});

        $display("[TB] reset in the middle of CALC");
        @(negedge clock);
        dividend = 32'd1000;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(negedge clock);
        checkOutput("midreset busy before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("midreset busy", 64'(busy), 64'd0);
        checkOutput("midreset done", 64'(done), 64'd0);
        checkOutput("midreset result", result, 64'd0);
        reset = 1'b0;
        runAndCheck("15/4 after reset", 32'd15, 32'd4, 32'd3, 32'd3, 1'b0, -1);

        $display("[TB] randomized runs against reference model");
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       a = 32'h8000_0000;
                1:       a = $urandom_range(0, 300);
                2:       a = -$urandom_range(0, 300);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 16);
                2:       b = -$urandom_range(1, 16);
                3:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            refModel(a, b, rq, rr, rz);
            runAndCheck($sformatf("rand%0d 0x%0h/0x%0h", n, a, b), a, b, rq, rr, rz,
                        rz ? -1 : int'($urandom_range(0, 31)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
